// File: rtl/sevenseg_scan_driver_if.sv
// Display bus for sevenseg_scan_driver: datapath-side data/load/enable inputs
// and the multiplexed pin outputs.
interface sevenseg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  E;
    logic                  load;
    logic [4*DIGITS-1:0]   D;
    logic [DIGITS-1:0]     DP;
    logic                  pending;
    logic [DIGITS-1:0]     AN;
    logic [7:0]            P;

    // Datapath / stimulus side
    modport master (
        output E, load, D, DP,
        input  pending, AN, P
    );

    // Display driver side
    modport slave (
        input  E, load, D, DP,
        output pending, AN, P
    );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed hex 7-segment scan driver with a double-buffered load.
// Data is captured into a shadow register and swapped into the displayed
// (active) register only at a frame boundary, so a frame never tears.
// Optional macro SEVENSEG_LZ_BLANK_EN enables leading-zero blanking.
module sevenseg_scan_driver #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    sevenseg_scan_driver_if.slave bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = 5 * DIGITS;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]     presc_reg;
    logic [IW-1:0]     idx_reg;
    logic [BW-1:0]     shadow_reg;
    logic [BW-1:0]     active_reg;
    logic              pending_reg;
    logic [DIGITS-1:0] an_reg;
    logic [7:0]        p_reg;

    logic              tick;
    logic              frame_end;
    logic [BW-1:0]     load_word;

    // Word layout: {D, DP}, nibbles in the upper 4*DIGITS bits
    assign load_word = {bus.D, bus.DP};
    assign tick      = (presc_reg == PRESC_LAST);
    assign frame_end = tick && (idx_reg == IDX_LAST);

    // Refresh prescaler: counts 0..DIV-1 and wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            presc_reg <= '0;
        else if (tick)
            presc_reg <= '0;
        else
            presc_reg <= presc_reg + 1'b1;
    end

    // Digit-scan index: advances on tick, wraps explicitly at DIGITS-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idx_reg <= '0;
        else if (tick)
            idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end

    // Double buffer: load fills shadow, frame end promotes shadow (or a
    // same-cycle load directly) into the displayed register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_reg  <= '0;
            active_reg  <= '0;
            pending_reg <= 1'b0;
        end else if (frame_end) begin
            if (bus.load) begin
                active_reg  <= load_word;
                shadow_reg  <= load_word;
                pending_reg <= 1'b0;
            end else if (pending_reg) begin
                active_reg  <= shadow_reg;
                pending_reg <= 1'b0;
            end
        end else if (bus.load) begin
            shadow_reg  <= load_word;
            pending_reg <= 1'b1;
        end
    end

    // Hex to abcdefg segment pattern
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    logic [3:0]        nib [DIGITS];
    logic [DIGITS-1:0] active_dp;

    assign active_dp = active_reg[DIGITS-1:0];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign nib[gi] = active_reg[DIGITS + 4*gi +: 4];
        end
    endgenerate

    logic [6:0] seg_vis;

`ifdef SEVENSEG_LZ_BLANK_EN
    // zero_from[k]: nibble k and every higher nibble are zero
    logic [DIGITS-1:0] zero_from;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
            if (gi == DIGITS - 1) begin : g_top
                assign zero_from[gi] = (nib[gi] == 4'h0);
            end else begin : g_chain
                assign zero_from[gi] = (nib[gi] == 4'h0) && zero_from[gi+1];
            end
        end
    endgenerate

    // Digit 0 always shows, so an all-zero value still reads "0"
    always_comb begin
        seg_vis = seg7(nib[idx_reg]);
        if ((idx_reg != '0) && zero_from[idx_reg])
            seg_vis = '0;
    end
`else
    // Every digit decoded unconditionally
    always_comb begin
        seg_vis = seg7(nib[idx_reg]);
    end
`endif

    logic [DIGITS-1:0] an_onehot;

    // One-hot anode select for the current digit
    always_comb begin
        an_onehot          = '0;
        an_onehot[idx_reg] = 1'b1;
    end

    // Registered pin outputs, blanked while E is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_reg <= '0;
            p_reg  <= '0;
        end else if (bus.E) begin
            an_reg <= an_onehot;
            p_reg  <= {seg_vis, active_dp[idx_reg]};
        end else begin
            an_reg <= '0;
            p_reg  <= '0;
        end
    end

    assign bus.pending = pending_reg;
    assign bus.AN      = an_reg;
    assign bus.P       = p_reg;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed, table-driven bench for sevenseg_scan_driver (DIGITS=4, DIV=4).
// A frame is 16 clocks; cnt counts rising edges since reset release, so the
// swap edge is cnt%16==0 and digit k is on the pins at cnt%16 in 4k+1..4k+4.
module tb_sevenseg_scan_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cnt;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sevenseg_scan_driver_if #(.DIGITS(4)) bus ();

    sevenseg_scan_driver #(.DIGITS(4), .DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= 0;
        else     cnt <= cnt + 1;
    end

    typedef struct {
        logic [15:0] d;
        logic [3:0]  dp;
        logic [31:0] p;     // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t       vecs [24];
    int         nvec;
    logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cnt=%0d)", name, act, exp, cnt);
        end
    endtask

    task automatic wait_phase(input int r);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((cnt % 16 != r) && (k < 64));
        if (cnt % 16 != r) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_phase: got phase %0d, expected %0d", cnt % 16, r);
        end
    endtask

    // Called at the swap negedge (cnt%16==0); checks the next full frame
    task automatic check_frame(input string tag, input logic [31:0] exp_p);
        logic [3:0] one;
        int k;
        one = 4'b0001;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            k = (j - 1) / 4;
            chk({tag, ".AN"}, 32'(bus.AN), 32'(one << k));
            chk({tag, ".P"},  32'(bus.P),  32'(exp_p[8*k +: 8]));
        end
        $display("frame %s expected %h", tag, exp_p);
    endtask

    task automatic apply_vec(input int i);
        wait_phase(4);
        bus.load = 1'b1;
        bus.D    = vecs[i].d;
        bus.DP   = vecs[i].dp;
        @(negedge clk);
        bus.load = 1'b0;
        chk($sformatf("v%0d.pending_set", i), 32'(bus.pending), 32'd1);
        wait_phase(15);
        chk($sformatf("v%0d.pending_hold", i), 32'(bus.pending), 32'd1);
        @(negedge clk);
        chk($sformatf("v%0d.pending_clr", i), 32'(bus.pending), 32'd0);
        check_frame($sformatf("v%0d", i), vecs[i].p);
    endtask

    initial begin
        logic [3:0] xn;
        bus.E    = 1'b1;
        bus.load = 1'b0;
        bus.D    = '0;
        bus.DP   = '0;

        // Vector table
        vecs[0] = '{16'h1234, 4'b0000, 32'h60DAF266};
        for (int x = 0; x < 16; x++) begin
            xn = 4'(x);
            vecs[1+x].d  = {xn, xn, xn, xn};
            vecs[1+x].dp = 4'b0000;
            vecs[1+x].p  = {seg_tab[x], seg_tab[x], seg_tab[x], seg_tab[x]};
        end
        nvec = 17;
`ifdef SEVENSEG_LZ_BLANK_EN
        vecs[1].p = 32'h000000FC;
        vecs[nvec++] = '{16'h0070, 4'b0000, 32'h0000E0FC};
        vecs[nvec++] = '{16'h0000, 4'b0000, 32'h000000FC};
`endif
        vecs[nvec++] = '{16'hC6D8, 4'b0100, 32'h9CBF7AFE};

        // Power-on reset
        repeat (2) @(negedge clk);
        chk("por.P", 32'(bus.P), 32'h00);
        chk("por.AN", 32'(bus.AN), 32'h0);
        chk("por.pending", 32'(bus.pending), 32'd0);
        rst = 1'b0;

        // Reset mid-scan with a pending load
        wait_phase(4);
        bus.load = 1'b1;
        bus.D    = 16'h1234;
        @(negedge clk);
        bus.load = 1'b0;
        wait_phase(9);
        chk("pre_rst.pending", 32'(bus.pending), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst.P", 32'(bus.P), 32'h00);
        chk("rst.AN", 32'(bus.AN), 32'h0);
        chk("rst.pending", 32'(bus.pending), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk("post_rst.AN", 32'(bus.AN), 32'h1);
            chk("post_rst.P", 32'(bus.P), 32'hFC);
        end
        @(negedge clk);
        chk("post_rst.AN_step", 32'(bus.AN), 32'h2);
`ifdef SEVENSEG_LZ_BLANK_EN
        chk("post_rst.P_step", 32'(bus.P), 32'h00);
`else
        chk("post_rst.P_step", 32'(bus.P), 32'hFC);
`endif
        chk("post_rst.pending", 32'(bus.pending), 32'd0);

        // Table-driven decode vectors
        for (int i = 0; i < nvec; i++) begin
            apply_vec(i);
            $display("vector %0d D=%h DP=%b applied", i, vecs[i].d, vecs[i].dp);
        end

        // Enable low for 10 clocks mid-frame (active = C6D8, DP=0100)
        wait_phase(5);
        bus.E = 1'b0;
        for (int j = 6; j <= 15; j++) begin
            @(negedge clk);
            chk("elow.AN", 32'(bus.AN), 32'h0);
            chk("elow.P", 32'(bus.P), 32'h00);
        end
        bus.E = 1'b1;
        @(negedge clk);
        chk("eres.AN3", 32'(bus.AN), 32'h8);
        chk("eres.P3", 32'(bus.P), 32'h9C);
        @(negedge clk);
        chk("eres.AN0", 32'(bus.AN), 32'h1);
        chk("eres.P0", 32'(bus.P), 32'hFE);
        $display("enable gating sequence done");

        // Back-to-back loads: the last one wins
        wait_phase(4);
        bus.load = 1'b1;
        bus.D    = 16'h1111;
        bus.DP   = 4'b0000;
        @(negedge clk);
        bus.D    = 16'h2222;
        @(negedge clk);
        bus.load = 1'b0;
        wait_phase(0);
        check_frame("last_wins", 32'hDADADADA);

        // Load on the frame_end cycle bypasses the shadow
        wait_phase(15);
        chk("bypass.pre_pending", 32'(bus.pending), 32'd0);
        bus.load = 1'b1;
        bus.D    = 16'hABCD;
        bus.DP   = 4'b0000;
        @(negedge clk);
        bus.load = 1'b0;
        chk("bypass.pending", 32'(bus.pending), 32'd0);
        check_frame("bypass", 32'hEE3E9C7A);
        chk("bypass.pending_after", 32'(bus.pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
